fft_bitrev_reorder: RTL and testbench



---
 rtl/fft_bitrev_reorder_pkg.sv | 29 ++
 rtl/fft_bitrev_reorder_ram.sv | 36 +++
 rtl/fft_bitrev_reorder.sv | 105 ++++++++++
 tb/tb_fft_bitrev_reorder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_bitrev_reorder_pkg.sv
`default_nettype none
// =============================================================================
// Module      : fft_bitrev_reorder_pkg
// Description : Shared FFT constants and the bit-reversal helper.
// Revision    : 1.0 - initial release
// =============================================================================
package fft_bitrev_reorder_pkg;

    localparam int c_width     = 16;
    localparam int c_log_n     = 6;
    localparam int c_max_log_n = 16;

    // Reverses the low log_n bits of value; bits at and above log_n return 0.
    function automatic logic [c_max_log_n-1:0] bitrev(
        input logic [c_max_log_n-1:0] value,
        input int unsigned            log_n
    );
        logic [c_max_log_n-1:0] w_rev;
        w_rev = '0;
        for (int i = 0; i < c_max_log_n; i++) begin
            if (i < int'(log_n)) begin
                w_rev[i] = value[int'(log_n) - 1 - i];
            end
        end
        return w_rev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bitrev_reorder_ram.sv
`default_nettype none
// =============================================================================
// Module      : fft_bitrev_reorder_ram
// Description : Simple dual-port RAM, one write port, registered read port.
// Revision    : 1.0 - initial release
// =============================================================================
module fft_bitrev_reorder_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // No reset on purpose so the array and read register map onto block RAM.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// =============================================================================
// Module      : fft_bitrev_reorder
// Description : Ping-pong reorder of bit-reversed FFT frames to natural order.
// Revision    : 1.0 - initial release
// =============================================================================
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int LOG_N = c_log_n
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam logic [LOG_N-1:0] c_last = '1;
    localparam logic [LOG_N-1:0] c_one  = LOG_N'(1);

    logic [LOG_N-1:0]   r_wr_cnt;
    logic               r_wr_bank;
    logic [LOG_N-1:0]   r_rd_cnt;
    logic               r_rd_bank;
    logic               r_rd_active;
    logic               r_do_en;
    logic               r_out_loaded;
    logic [LOG_N-1:0]   w_wr_cnt_rev;
    logic               w_launch;
    logic [2*WIDTH-1:0] w_rd_data;

    generate
        for (genvar i = 0; i < LOG_N; i++) begin : g_bitrev
            assign w_wr_cnt_rev[i] = r_wr_cnt[LOG_N-1-i];
        end
    endgenerate

    assign w_launch = di_en && (r_wr_cnt == c_last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (di_en) begin
            r_wr_cnt <= r_wr_cnt + c_one;
            if (w_launch) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // A launch overrides the end-of-frame stop so back-to-back frames stream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_cnt    <= '0;
            r_rd_bank   <= 1'b0;
            r_rd_active <= 1'b0;
        end else if (w_launch) begin
            r_rd_cnt    <= '0;
            r_rd_bank   <= r_wr_bank;
            r_rd_active <= 1'b1;
        end else if (r_rd_active) begin
            r_rd_cnt <= r_rd_cnt + c_one;
            if (r_rd_cnt == c_last) begin
                r_rd_active <= 1'b0;
            end
        end
    end

    fft_bitrev_reorder_ram #(
        .DATA_W (2*WIDTH),
        .ADDR_W (LOG_N+1)
    ) u_ram (
        .clock     (clock),
        .i_wr_en   (di_en),
        .i_wr_addr ({r_wr_bank, w_wr_cnt_rev}),
        .i_wr_data ({di_re, di_im}),
        .i_rd_en   (r_rd_active),
        .i_rd_addr ({r_rd_bank, r_rd_cnt}),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_do_en      <= 1'b0;
            r_out_loaded <= 1'b0;
        end else begin
            r_do_en      <= r_rd_active;
            r_out_loaded <= r_out_loaded | r_rd_active;
        end
    end

    // The RAM read register is the output data register; it only loads while
    // reading, so it holds when idle. The mask gives zero data after reset.
    assign do_en = r_do_en;
    assign do_re = r_out_loaded ? w_rd_data[2*WIDTH-1:WIDTH] : '0;
    assign do_im = r_out_loaded ? w_rd_data[WIDTH-1:0]       : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// =============================================================================
// Module      : tb_fft_bitrev_reorder
// Description : Scoreboard bench for the bit-reversed to natural-order reorder.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_fft_bitrev_reorder;
    import fft_bitrev_reorder_pkg::*;

    localparam int c_n = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        di_en;
    logic [15:0] di_re;
    logic [15:0] di_im;
    logic        do_en;
    logic [15:0] do_re;
    logic [15:0] do_im;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0] sb [$];
    logic [31:0] tb_buf [c_n];
    int          tb_cnt       = 0;
    int          last_in_cyc  = 0;
    int          first_out_cyc = 0;
    int          run_len      = 0;
    int          last_run     = 0;
    int          total_out    = 0;
    logic        prev_en      = 1'b0;

    fft_bitrev_reorder #(.WIDTH(16), .LOG_N(6)) dut (
        .clock (clock),
        .reset (reset),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (do_en === 1'b1) begin
            if (!prev_en) begin
                first_out_cyc = cyc;
                run_len = 0;
            end
            run_len++;
            total_out++;
            check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                check("out_data", 64'({do_re, do_im}), 64'(sb.pop_front()));
            end
        end else if (prev_en) begin
            last_run = run_len;
        end
        prev_en = (do_en === 1'b1);
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            di_en = 1'b0;
        end
    endtask

    // Sample k of a frame carries re = base + bitrev(k), im = ~re.
    task automatic drive_samples(input int n, input int base, input int gap);
        logic [15:0] v;
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            v = 16'(base + int'(bitrev(16'(tb_cnt), c_log_n)));
            di_en = 1'b1;
            di_re = v;
            di_im = ~v;
            tb_buf[tb_cnt] = {v, ~v};
            if (tb_cnt == c_n - 1) begin
                for (int j = 0; j < c_n; j++) begin
                    sb.push_back(tb_buf[int'(bitrev(16'(j), c_log_n))]);
                end
                last_in_cyc = cyc;
            end
            tb_cnt = (tb_cnt + 1) % c_n;
            for (int g = 0; g < gap; g++) begin
                @(posedge clock); #1;
                di_en = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b1;
        di_en = 1'b0;
        tb_cnt = 0;
        sb.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || do_en === 1'b1) && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        repeat (2) @(negedge clock);
        check("drain_timeout", 64'(n >= budget), 64'd0);
    endtask

    initial begin
        int snap;
        int n;
        reset = 1'b1;
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_do_en", 64'(do_en), 64'd0);
        check("rst_do_data", 64'({do_re, do_im}), 64'd0);
        reset = 1'b0;

        // Idle after reset, then a 63-sample partial frame: no output at all.
        idle_cycles(50);
        check("idle_data", 64'({do_re, do_im}), 64'd0);
        drive_samples(63, 0, 0);
        idle_cycles(150);
        check("partial_no_out", 64'(total_out), 64'd0);
        check("partial_do_en", 64'(do_en), 64'd0);

        // Single contiguous frame.
        do_reset();
        drive_samples(64, 0, 0);
        idle_cycles(1);
        wait_drain(300);
        check("single_latency", 64'(first_out_cyc - last_in_cyc), 64'd2);
        check("single_run", 64'(last_run), 64'd64);
        check("idle_hold", 64'({do_re, do_im}), 64'({16'd63, ~16'd63}));

        // Four back-to-back frames must stream as one burst.
        for (int f = 0; f < 4; f++) drive_samples(64, f * 64, 0);
        idle_cycles(1);
        wait_drain(600);
        check("cont_run", 64'(last_run), 64'd256);
        check("cont_latency", 64'(first_out_cyc - (last_in_cyc - 192)), 64'd2);

        // Gapped input: one frame over 128 cycles.
        drive_samples(64, 16'h0400, 1);
        idle_cycles(1);
        wait_drain(400);
        check("gap_run", 64'(last_run), 64'd64);
        check("gap_latency", 64'(first_out_cyc - last_in_cyc), 64'd2);

        // Reset after 30 samples, then a clean frame.
        drive_samples(30, 16'h0800, 0);
        snap = total_out;
        do_reset();
        check("midframe_rst_no_out", 64'(total_out - snap), 64'd0);
        drive_samples(64, 16'h0100, 0);
        idle_cycles(1);
        wait_drain(300);
        check("midframe_run", 64'(last_run), 64'd64);
        check("midframe_latency", 64'(first_out_cyc - last_in_cyc), 64'd2);

        // Reset while output index 20 is on the bus.
        drive_samples(64, 16'h0200, 0);
        idle_cycles(1);
        n = 0;
        while (!(prev_en && run_len == 20) && n < 300) begin
            @(posedge clock); #3;
            n++;
        end
        check("readout_wait_timeout", 64'(n >= 300), 64'd0);
        check("readout_active", 64'(do_en), 64'd1);
        check("readout_idx20", 64'(do_re), 64'h0214);
        reset = 1'b1;
        #1;
        check("async_rst_do_en", 64'(do_en), 64'd0);
        check("async_rst_data", 64'({do_re, do_im}), 64'd0);
        sb.delete();
        tb_cnt = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        snap = total_out;
        idle_cycles(100);
        check("post_rst_no_out", 64'(total_out - snap), 64'd0);
        drive_samples(64, 16'h0300, 0);
        idle_cycles(1);
        wait_drain(300);
        check("post_rst_run", 64'(last_run), 64'd64);
        check("post_rst_latency", 64'(first_out_cyc - last_in_cyc), 64'd2);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
